multicycle_control_unit: RTL and testbench

Multi-cycle control FSM for the RV32I subset core (add/sub, addi, lw, sw, beq/bne). It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB sequence. It latches the instruction internally, handshakes with instruction and data memory, traps on illegal opcodes and memory timeouts, and counts retired instructions. It sits between the imem/dmem ports and the datapath muxes, register file and PC register.

---
 rtl/multicycle_control_unit.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I subset core.
// Optional BRANCH_LT_EN macro adds blt/bge decode.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          im_data,
    input  logic                 im_valid,
    input  logic                 ALUzero,
    input  logic                 ALUlt,
    input  logic                 dmem_ready,
    output logic                 ir_load,
    output logic                 PCwrite,
    output logic                 PCsrc,
    output logic                 RegWrite,
    output logic                 ALUsrc,
    output logic [1:0]           ALUctl,
    output logic                 MemtoReg,
    output logic                 dmem_req,
    output logic                 MemWrite,
    output logic                 trap,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [2:0]           state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic [TO_W-1:0]      wcnt_q, wcnt_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 retire;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       is_r, is_addi, is_lw, is_sw, is_br;
    logic       br_legal, br_taken, illegal;
    logic       unused_bits;

    assign opc = ir_q[6:0];
    assign f3  = ir_q[14:12];
    assign f7  = ir_q[31:25];

    assign is_r    = (opc == OP_R);
    assign is_addi = (opc == OP_ADDI);
    assign is_lw   = (opc == OP_LW);
    assign is_sw   = (opc == OP_SW);
    assign is_br   = (opc == OP_BR);

`ifdef BRANCH_LT_EN
    assign br_legal = (f3 == 3'b000) || (f3 == 3'b001) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
    assign unused_bits = ^{ir_q[24:15], ir_q[11:7]};
`else
    assign br_legal = (f3 == 3'b000) || (f3 == 3'b001);
    assign unused_bits = ^{ir_q[24:15], ir_q[11:7], ALUlt};
`endif

    assign illegal = !(is_r || is_addi || is_lw || is_sw || is_br) ||
                     (is_r && f7 != 7'h00 && f7 != 7'h20) ||
                     (is_br && !br_legal);

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000:  br_taken = ALUzero;
            3'b001:  br_taken = !ALUzero;
`ifdef BRANCH_LT_EN
            3'b100:  br_taken = ALUlt;
            3'b101:  br_taken = !ALUlt;
`endif
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            wcnt_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wcnt_q    <= wcnt_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wcnt_d  = wcnt_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (im_valid) begin
                    ir_d    = im_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                wcnt_d = '0;
                unique case (1'b1)
                    is_r, is_addi: state_d = S_WB;
                    is_lw, is_sw:  state_d = S_MEM;
                    is_br: begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default:       state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                // a completion on the limit cycle beats the timeout
                if (dmem_ready) begin
                    retire  = is_sw;
                    state_d = is_sw ? S_FETCH : S_WB;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        instret_d = instret_q + INSTRET_W'(retire);
    end

    always_comb begin
        ir_load  = 1'b0;
        PCwrite  = 1'b0;
        PCsrc    = 1'b0;
        RegWrite = 1'b0;
        ALUsrc   = 1'b0;
        ALUctl   = 2'b00;
        MemtoReg = 1'b0;
        dmem_req = 1'b0;
        MemWrite = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: ir_load = im_valid;
                S_EXEC: begin
                    unique case (1'b1)
                        is_r: ALUctl = {1'b0, f7[5]};
                        is_addi, is_lw, is_sw: ALUsrc = 1'b1;
                        is_br: begin
                            ALUctl  = 2'b01;
                            PCwrite = 1'b1;
                            PCsrc   = br_taken;
                        end
                        default: ALUctl = 2'b00;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    ALUsrc   = 1'b1;
                    MemWrite = is_sw;
                    PCwrite  = is_sw && dmem_ready;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCwrite  = 1'b1;
                    MemtoReg = is_lw;
                end
                default: ir_load = 1'b0;
            endcase
        end
    end

    assign trap    = (state_q == S_TRAP);
    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit.
// Build with +define+BRANCH_LT_EN to cover blt/bge decode.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] im_data;
    logic        im_valid;
    logic        ALUzero;
    logic        ALUlt;
    logic        dmem_ready;
    logic        ir_load, PCwrite, PCsrc, RegWrite, ALUsrc;
    logic [1:0]  ALUctl;
    logic        MemtoReg, dmem_req, MemWrite, trap;
    logic [2:0]  state;
    logic [31:0] instret;

    int nvec = 0;
    int nbad = 0;

    multicycle_control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .im_data   (im_data),
        .im_valid  (im_valid),
        .ALUzero   (ALUzero),
        .ALUlt     (ALUlt),
        .dmem_ready(dmem_ready),
        .ir_load   (ir_load),
        .PCwrite   (PCwrite),
        .PCsrc     (PCsrc),
        .RegWrite  (RegWrite),
        .ALUsrc    (ALUsrc),
        .ALUctl    (ALUctl),
        .MemtoReg  (MemtoReg),
        .dmem_req  (dmem_req),
        .MemWrite  (MemWrite),
        .trap      (trap),
        .state     (state),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        im_valid   = 1'b0;
        dmem_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_trap", 32'(trap), 0);
        check("rst_instret", instret, 0);
    endtask

    // present an instruction in FETCH; returns in DECODE with im lines scrambled
    task automatic fetch(input logic [31:0] ins);
        im_data  = ins;
        im_valid = 1'b1;
        #1;
        check("fetch_state", 32'(state), 0);
        check("fetch_irload", 32'(ir_load), 1);
        tick();
        im_valid = 1'b0;
        im_data  = 32'hFFFF_FFFF;
        #1;
        check("dec_state", 32'(state), 1);
        check("dec_strobes", 32'({PCwrite, RegWrite, dmem_req, ir_load}), 0);
    endtask

    initial begin
        rst        = 1'b1;
        im_data    = 32'h0;
        im_valid   = 1'b1;
        ALUzero    = 1'b0;
        ALUlt      = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("rst_force_irload", 32'(ir_load), 0);
        tick();
        do_reset();

        // FETCH holds without im_valid
        tick();
        check("fetch_hold", 32'(state), 0);
        check("fetch_hold_irload", 32'(ir_load), 0);

        // add
        fetch(32'h002081B3);
        tick();
        check("add_exec", 32'(state), 2);
        check("add_ctl", 32'({ALUsrc, ALUctl}), 32'b000);
        tick();
        check("add_wb", 32'(state), 4);
        check("add_wb_str", 32'({RegWrite, PCwrite, PCsrc, MemtoReg}), 32'b1100);
        tick();
        check("add_done", 32'(state), 0);
        check("add_instret", instret, 1);

        // sub
        fetch(32'h402081B3);
        tick();
        check("sub_ctl", 32'({ALUsrc, ALUctl}), 32'b001);
        tick();
        check("sub_wb", 32'(state), 4);
        tick();
        check("sub_instret", instret, 2);

        // lw with three wait cycles
        fetch(32'h0080A283);
        tick();
        check("lw_exec_src", 32'(ALUsrc), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            dmem_ready = (i == 3);
            #1;
            check("lw_mem_state", 32'(state), 3);
            check("lw_mem_req", 32'({dmem_req, MemWrite, PCwrite}), 32'b100);
        end
        tick();
        dmem_ready = 1'b0;
        check("lw_wb", 32'(state), 4);
        check("lw_wb_str", 32'({RegWrite, MemtoReg, PCwrite}), 32'b111);
        tick();
        check("lw_instret", instret, 3);

        // beq taken
        fetch(32'h00208463);
        tick();
        ALUzero = 1'b1;
        #1;
        check("beq_str", 32'({PCwrite, PCsrc, ALUctl}), 32'b1101);
        tick();
        check("beq_done", 32'(state), 0);
        check("beq_instret", instret, 4);

        // bne not taken
        fetch(32'h00209463);
        tick();
        check("bne_str", 32'({PCwrite, PCsrc}), 32'b10);
        tick();
        ALUzero = 1'b0;
        check("bne_instret", instret, 5);

        // sw completing on the very limit cycle
        fetch(32'h0050A623);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            dmem_ready = (i == 14);
            #1;
            check("swlim_mem", 32'({state, dmem_req, MemWrite}), 32'b01111);
        end
        check("swlim_pcw", 32'(PCwrite), 1);
        tick();
        dmem_ready = 1'b0;
        check("swlim_done", 32'(state), 0);
        check("swlim_instret", instret, 6);

        // sw timeout
        fetch(32'h0050A623);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            check("swto_mem", 32'({state, dmem_req, MemWrite}), 32'b01111);
        end
        tick();
        check("swto_state", 32'(state), 5);
        check("swto_trap", 32'({trap, dmem_req, PCwrite}), 32'b100);
        check("swto_instret", instret, 6);
        im_valid = 1'b1;
        tick();
        check("trap_sticky", 32'({state, ir_load}), 32'b1010);
        do_reset();

        // all-zero word traps in DECODE
        fetch(32'h00000000);
        tick();
        check("zero_trap", 32'({state, trap}), 32'b1011);
        do_reset();

        // bad R-type funct7
        fetch(32'h022081B3);
        tick();
        check("f7_trap", 32'(state), 5);
        do_reset();

        // blt
        ALUlt = 1'b1;
        fetch(32'h0020C463);
        tick();
`ifdef BRANCH_LT_EN
        check("blt_exec", 32'({state, PCwrite, PCsrc, ALUctl}), 32'b0101101);
        tick();
        check("blt_instret", instret, 1);
`else
        check("blt_trap", 32'({state, trap}), 32'b1011);
`endif
        ALUlt = 1'b0;
        do_reset();

        // reset in the middle of MEM
        fetch(32'h0080A283);
        tick();
        tick();
        check("rmem_req", 32'(dmem_req), 1);
        rst = 1'b1;
        #1;
        check("rmem_drop", 32'(dmem_req), 0);
        tick();
        rst = 1'b0;
        #1;
        check("rmem_state", 32'(state), 0);
        check("rmem_instret", instret, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
